// File: rtl/shift_norm_feeder.sv
// Two-stage valid/ready feeder for the left barrel shifter: pairs each operand with a
// shift magnitude (leading-zero count or caller-supplied) and counts zero operands emitted.
module shift_norm_feeder #(
  parameter int WIDTH = 16,
  parameter int MAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [MAG_W-1:0] in_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op_out,
  output logic [MAG_W-1:0] shift_mag,
  output logic             out_zero,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] zero_cnt
);

  logic             r_rst_meta, r_rst_sync;
  logic             r_s1_valid, r_s1_mode;
  logic [WIDTH-1:0] r_s1_data;
  logic [MAG_W-1:0] r_s1_mag;
  logic             r_s2_valid, r_s2_zero;
  logic [WIDTH-1:0] r_s2_op;
  logic [MAG_W-1:0] r_s2_mag;
  logic [CNT_W-1:0] r_zero_cnt;

  logic             w_s1_ready, w_s2_ready, w_in_hs, w_out_hs, w_found;
  logic [MAG_W-1:0] w_lzc;

  // Reset asserts asynchronously but releases on a clock edge, two flops deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= 1'b1;
    end else begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_s2_ready = !r_s2_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  // Held low until the internal reset has released so nothing is accepted into a clearing pipe.
  assign in_ready   = w_s1_ready && !r_rst_sync;
  assign w_in_hs    = in_valid && in_ready;
  assign w_out_hs   = r_s2_valid && out_ready;

  always_ff @(posedge clk or posedge r_rst_sync) begin
    if (r_rst_sync) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mag   <= '0;
    end else begin
      if (w_s1_ready) r_s1_valid <= w_in_hs;
      if (w_in_hs) begin
        r_s1_data <= in_data;
        r_s1_mode <= in_mode;
        r_s1_mag  <= in_mag;
      end
    end
  end

  // Leading-zero count, scanned from the MSB; an all-zero operand yields 0.
  always_comb begin
    w_lzc   = '0;
    w_found = 1'b0;
    for (int i = WIDTH-1; i >= 0; i--) begin
      if (!w_found && r_s1_data[i]) begin
        w_lzc   = MAG_W'(WIDTH-1-i);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge r_rst_sync) begin
    if (r_rst_sync) begin
      r_s2_valid <= 1'b0;
      r_s2_op    <= '0;
      r_s2_mag   <= '0;
      r_s2_zero  <= 1'b0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_op   <= r_s1_data;
        r_s2_mag  <= r_s1_mode ? r_s1_mag : w_lzc;
        r_s2_zero <= (r_s1_data == '0);
      end
    end
  end

  // Saturating zero-operand counter; a clear outranks a same-cycle increment.
  always_ff @(posedge clk or posedge r_rst_sync) begin
    if (r_rst_sync) begin
      r_zero_cnt <= '0;
    end else if (clr_stats) begin
      r_zero_cnt <= '0;
    end else if (w_out_hs && r_s2_zero && (r_zero_cnt != {CNT_W{1'b1}})) begin
      r_zero_cnt <= r_zero_cnt + 1'b1;
    end
  end

  assign out_valid = r_s2_valid;
  assign op_out    = r_s2_op;
  assign shift_mag = r_s2_mag;
  assign out_zero  = r_s2_zero;
  assign zero_cnt  = r_zero_cnt;

endmodule

// File: tb/tb_shift_norm_feeder.sv
// Bench for shift_norm_feeder: queue-based reference model checked every cycle, directed
// literal cases, and a randomized valid/ready phase; a CNT_W=2 copy tracks counter saturation.
module tb_shift_norm_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_mode, out_ready, clr_stats;
  logic [15:0] in_data;
  logic [3:0]  in_mag;

  logic        in_ready, out_valid, out_zero;
  logic [15:0] op_out;
  logic [3:0]  shift_mag;
  logic [15:0] zero_cnt;

  logic        s_in_ready, s_out_valid, s_zero;
  logic [15:0] s_op;
  logic [3:0]  s_mag;
  logic [1:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_norm_feeder #(.WIDTH(16), .MAG_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_mag(in_mag), .out_valid(out_valid), .out_ready(out_ready),
    .op_out(op_out), .shift_mag(shift_mag), .out_zero(out_zero), .clr_stats(clr_stats),
    .zero_cnt(zero_cnt));

  shift_norm_feeder #(.WIDTH(16), .MAG_W(4), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_mag(in_mag), .out_valid(s_out_valid), .out_ready(out_ready),
    .op_out(s_op), .shift_mag(s_mag), .out_zero(s_zero), .clr_stats(clr_stats),
    .zero_cnt(s_cnt));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] op;
    logic [3:0]  mag;
    logic        zero;
    int          t;
  } item_t;

  item_t q[$];
  int    e     = 0;   // posedges seen
  int    leave = -1;  // edge at which the last item was handed downstream
  int    hold  = 2;   // edges still to go before the block takes input after reset
  int    m_cnt = 0;
  int    m_scnt = 0;

  function automatic logic [3:0] ref_lzc(input logic [15:0] v);
    int n = 0;
    if (v == 16'h0) return 4'd0;
    while (!v[15]) begin
      v = v << 1;
      n++;
    end
    return 4'(n);
  endfunction

  // An item is visible two cycles after it was presented, and not before its predecessor left.
  function automatic bit m_ov();
    return (q.size() > 0) && (e >= q[0].t + 2) && (e >= leave + 1);
  endfunction

  function automatic bit m_rdy();
    return (hold == 0) && ((q.size() < 2) || (m_ov() && out_ready));
  endfunction

  bit p_ov, p_ohs, p_ihs;
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_cnt = 0; m_scnt = 0; hold = 2; leave = -1;
    end else begin
      p_ov  = m_ov();
      p_ohs = p_ov && out_ready;
      p_ihs = in_valid && m_rdy();
      if (clr_stats) begin
        m_cnt = 0; m_scnt = 0;
      end else if (p_ohs && q[0].zero) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_scnt < 3) m_scnt++;
      end
      if (p_ohs) begin
        void'(q.pop_front());
        leave = e;
      end
      if (p_ihs) q.push_back('{in_data, in_mode ? in_mag : ref_lzc(in_data), in_data == 16'h0, e});
      if (hold > 0) hold--;
    end
    e++;
  end

  bit c_ov;
  always @(negedge clk) begin
    #3;
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_zero_cnt", 32'(zero_cnt), 0);
      chk("rst_zero_cnt_small", 32'(s_cnt), 0);
    end else begin
      c_ov = m_ov();
      chk("out_valid", 32'(out_valid), 32'(c_ov));
      chk("in_ready", 32'(in_ready), 32'(m_rdy()));
      chk("small_out_valid", 32'(s_out_valid), 32'(c_ov));
      if (c_ov) begin
        chk("op_out", 32'(op_out), 32'(q[0].op));
        chk("shift_mag", 32'(shift_mag), 32'(q[0].mag));
        chk("out_zero", 32'(out_zero), 32'(q[0].zero));
      end
      chk("zero_cnt", 32'(zero_cnt), m_cnt);
      chk("zero_cnt_small", 32'(s_cnt), m_scnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic v, input logic [15:0] d, input logic m, input logic [3:0] g,
                     input logic ordy, input logic clr, output logic acc);
    @(negedge clk);
    #1;
    in_valid = v; in_data = d; in_mode = m; in_mag = g; out_ready = ordy; clr_stats = clr;
    #3;
    acc = v && in_ready;
  endtask

  task automatic send_one(input logic [15:0] d, input logic m, input logic [3:0] g,
                          input logic [15:0] eop, input logic [3:0] emag, input logic ez);
    logic acc;
    cyc(1'b1, d, m, g, 1'b1, 1'b0, acc);
    chk("send_accept", 32'(acc), 1);
    cyc(1'b0, 16'h0, 1'b0, 4'h0, 1'b1, 1'b0, acc);
    @(negedge clk);
    #3;
    chk("lat_out_valid", 32'(out_valid), 1);
    chk("lat_op_out", 32'(op_out), 32'(eop));
    chk("lat_shift_mag", 32'(shift_mag), 32'(emag));
    chk("lat_out_zero", 32'(out_zero), 32'(ez));
  endtask

  logic [15:0] bp [4];
  int          sat_exp [8];
  int          idx;
  logic        acc, pend, pm;
  logic [15:0] pd;
  logic [3:0]  pg;

  initial begin
    bp[0] = 16'h0003; bp[1] = 16'h0000; bp[2] = 16'h4000; bp[3] = 16'h0101;
    sat_exp[0] = 0; sat_exp[1] = 0; sat_exp[2] = 0; sat_exp[3] = 1;
    sat_exp[4] = 2; sat_exp[5] = 3; sat_exp[6] = 3; sat_exp[7] = 3;

    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; in_mode = 1'b0; in_mag = 4'h0;
    out_ready = 1'b0; clr_stats = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_op_out", 32'(op_out), 0);
    chk("reset_shift_mag", 32'(shift_mag), 0);
    chk("reset_out_zero", 32'(out_zero), 0);
    chk("reset_zero_cnt", 32'(zero_cnt), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    cyc(1'b0, 16'h0, 1'b0, 4'h0, 1'b1, 1'b0, acc);
    cyc(1'b0, 16'h0, 1'b0, 4'h0, 1'b1, 1'b0, acc);

    // Normalise and explicit modes
    send_one(16'h0001, 1'b0, 4'h0, 16'h0001, 4'd15, 1'b0);
    send_one(16'h8000, 1'b0, 4'h7, 16'h8000, 4'd0,  1'b0);
    send_one(16'h00F0, 1'b0, 4'h0, 16'h00F0, 4'd8,  1'b0);
    send_one(16'h0000, 1'b0, 4'h0, 16'h0000, 4'd0,  1'b1);
    @(negedge clk);
    #3 chk("zero_cnt_first", 32'(zero_cnt), 1);
    send_one(16'h00F0, 1'b1, 4'd4,  16'h00F0, 4'd4,  1'b0);
    send_one(16'h00F0, 1'b1, 4'd15, 16'h00F0, 4'd15, 1'b0);
    send_one(16'h0000, 1'b1, 4'd9,  16'h0000, 4'd9,  1'b1);

    // Backpressure: 5 stalled cycles with 4 items offered
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(idx < 4, bp[idx], 1'b0, 4'h0, 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_accepts", idx, 2);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    chk("bp_head_held", 32'(op_out), 32'h0003);
    for (int c = 0; c < 12; c++) begin
      cyc(idx < 4, (idx < 4) ? bp[idx] : 16'h0, 1'b0, 4'h0, 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_all_accepted", idx, 4);

    // Reset with two items in flight
    cyc(1'b1, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, acc);
    cyc(1'b1, 16'h0002, 1'b0, 4'h0, 1'b0, 1'b0, acc);
    @(negedge clk);
    #1 rst = 1'b1; in_valid = 1'b0;
    #2;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_zero_cnt", 32'(zero_cnt), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    cyc(1'b0, 16'h0, 1'b0, 4'h0, 1'b1, 1'b0, acc);
    cyc(1'b0, 16'h0, 1'b0, 4'h0, 1'b1, 1'b0, acc);
    send_one(16'h1234, 1'b1, 4'd3, 16'h1234, 4'd3, 1'b0);

    // Saturation on the CNT_W=2 copy, then clear beating an increment
    cyc(1'b0, 16'h0, 1'b0, 4'h0, 1'b1, 1'b1, acc);
    for (int j = 0; j < 8; j++) begin
      cyc(j < 5, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b0, acc);
      chk("sat_cnt_small", 32'(s_cnt), sat_exp[j]);
    end
    chk("cnt16_after_five", 32'(zero_cnt), 5);
    cyc(1'b1, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b0, acc);
    cyc(1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b0, acc);
    cyc(1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b1, acc);
    cyc(1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b0, acc);
    chk("clr_wins_small", 32'(s_cnt), 0);
    chk("clr_wins_cnt16", 32'(zero_cnt), 0);

    // Randomized traffic with held-until-accepted inputs
    pend = 1'b0; pd = 16'h0; pm = 1'b0; pg = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend && ($urandom_range(3) != 0)) begin
        case ($urandom_range(5))
          0:       pd = 16'h0000;
          1:       pd = 16'(1) << $urandom_range(15);
          2:       pd = 16'($urandom_range(255));
          default: pd = 16'($urandom);
        endcase
        pm = 1'($urandom);
        pg = 4'($urandom);
        pend = 1'b1;
      end
      cyc(pend, pd, pm, pg, $urandom_range(3) != 0, $urandom_range(63) == 0, acc);
      if (acc) pend = 1'b0;
    end
    for (int c = 0; c < 4; c++) cyc(1'b0, 16'h0, 1'b0, 4'h0, 1'b1, 1'b0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
